// File: rtl/instr_seq_pkg.sv
// Shared types and encodings for the 10-bit processor instruction sequencer.
package instr_seq_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DATA_W = 10;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_SUBI = 2'b11;

  localparam logic [3:0] LOAD = 4'b0000;
  localparam logic [3:0] COPY = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0011;
  localparam logic [3:0] INV  = 4'b0100;
  localparam logic [3:0] FLIP = 4'b0101;
  localparam logic [3:0] AND  = 4'b0110;
  localparam logic [3:0] OR   = 4'b0111;
  localparam logic [3:0] XOR  = 4'b1000;
  localparam logic [3:0] LSL  = 4'b1001;
  localparam logic [3:0] LSR  = 4'b1010;
  localparam logic [3:0] ASR  = 4'b1011;

endpackage

// File: rtl/instr_sequencer_fifo.sv
// Synchronous instruction FIFO; the head word is visible combinationally.
module seq_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign do_push = push && !full;
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset so it can map onto RAM; only pointers are flushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (!do_push && do_pop) level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host words, fetches at T=0, steps T until Clr.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic              halt,
  input  logic              Clr,
  output logic [1:0]        T,
  output logic [DATA_W-1:0] DIN,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     retired,
  output logic [AW:0]       level
);

  state_t            state;
  logic              halt_pend;
  logic              fetch;
  logic              retire;
  logic              stop;
  logic              full;
  logic [DATA_W-1:0] head;

  seq_fifo #(.DEPTH(DEPTH), .AW(AW), .W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_valid),
    .push_data (load_data),
    .pop       (fetch),
    .head      (head),
    .full      (full),
    .level     (level)
  );

  assign load_ready = !full;
  assign busy       = (state == RUN);
  assign fetch      = (state == RUN) && (T == T0);
  // A missing Clr at T3 still retires the instruction so the run cannot stall.
  assign retire     = (state == RUN) && (T != T0) && (Clr || T == T3);
  assign stop       = halt_pend || halt || (level == '0);
  assign DIN        = fetch ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      T         <= T0;
      halt_pend <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          T         <= T0;
          halt_pend <= 1'b0;
          if (start && level != '0) state <= RUN;
        end
        RUN: begin
          if (halt) halt_pend <= 1'b1;
          if (T == T0) begin
            T <= T1;
          end else if (retire) begin
            retired <= retired + CW'(1);
            if (!Clr) err <= 1'b1;
            T <= T0;
            if (stop) begin
              state     <= IDLE;
              done      <= 1'b1;
              halt_pend <= 1'b0;
            end
          end else begin
            T <= T + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
